dot_clock_gen: RTL and testbench



---
 rtl/dot_clock_gen_pkg.sv | 7 +
 rtl/reset_sync.sv | 13 +
 rtl/dot_clock_gen.sv | 51 +++++
 tb/tb_dot_clock_gen.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/dot_clock_gen_pkg.sv
// dot_clock_gen_pkg: shared constants and helpers for the VGA dot clock divider.
package dot_clock_gen_pkg;
  localparam int DOT_DIV_VGA640 = 2;
  function automatic int high_count(input int div);
    return (div + 1) / 2;
  endfunction
endpackage

// File: rtl/reset_sync.sv
// reset_sync: two-flop reset synchronizer, asserts asynchronously and releases on the 2nd clk edge.
module reset_sync (
  input  logic clk,
  input  logic arst_n,
  output logic srst_n
);
  logic [1:0] sync_q, sync_d;
  always_comb sync_d = {sync_q[0], 1'b1};
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) sync_q <= '0;
    else sync_q <= sync_d;
  assign srst_n = sync_q[1];
endmodule

// File: rtl/dot_clock_gen.sv
// dot_clock_gen: divides the board clock by DIV into the VGA dot clock.
module dot_clock_gen
  import dot_clock_gen_pkg::*;
#(
  parameter int DIV   = DOT_DIV_VGA640,
  parameter int CNT_W = 16
) (
  input  logic board,
  input  logic rst_n,
  output logic dotclock
);
  if (DIV < 2 || DIV > 65535) begin : g_bad_div
    $error("dot_clock_gen: DIV must be in 2..65535");
  end
  if (CNT_W < 1 || (CNT_W < 32 && longint'(DIV) > (longint'(1) << CNT_W))) begin : g_bad_cnt_w
    $error("dot_clock_gen: CNT_W too narrow for DIV");
  end
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HIGH = CNT_W'(high_count(DIV));
  logic irst_n;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic pos_q, pos_d;
  reset_sync u_reset_sync (
    .clk    (board),
    .arst_n (rst_n),
    .srst_n (irst_n)
  );
  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    pos_d = cnt_d < HIGH;
  end
  always_ff @(posedge board or negedge irst_n)
    if (!irst_n) begin
      cnt_q <= LAST;
      pos_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pos_q <= pos_d;
    end
  if (DIV % 2 == 0) begin : g_even
    assign dotclock = pos_q;
  end else begin : g_odd
    // Half-cycle delayed copy trims the high phase so odd ratios stay balanced.
    logic neg_q, neg_d;
    always_comb neg_d = pos_q;
    always_ff @(negedge board or negedge irst_n)
      if (!irst_n) neg_q <= 1'b0;
      else neg_q <= neg_d;
    assign dotclock = pos_q & neg_q;
  end
endmodule

// File: tb/tb_dot_clock_gen.sv
// tb_dot_clock_gen: checks DIV=2,3,4,5 dividers side by side, including a mid-run reset.
module tb_dot_clock_gen;
  logic board = 1'b0;
  logic rst_n;
  wire [3:0] dc;
  always #10 board = ~board;
  dot_clock_gen #(.DIV(2)) u_d2 (.board(board), .rst_n(rst_n), .dotclock(dc[0]));
  dot_clock_gen #(.DIV(3)) u_d3 (.board(board), .rst_n(rst_n), .dotclock(dc[1]));
  dot_clock_gen #(.DIV(4)) u_d4 (.board(board), .rst_n(rst_n), .dotclock(dc[2]));
  dot_clock_gen #(.DIV(5)) u_d5 (.board(board), .rst_n(rst_n), .dotclock(dc[3]));
  typedef struct {
    int div;
    int first;
    int per;
    int hi;
  } row_t;
  row_t tbl [4];
  int tests = 0;
  int fails = 0;
  int p = 0;
  int rel = 0;
  logic [3:0] sbq [$];
  int first_r [4];
  int last_r [4];
  int per_l [4];
  int hi_l [4];
  int nper [4];
  int nbad [4];
  int nalign [4];
  int chg [4];
  int snap [4];
  logic [3:0] dc_prev = 4'b0;
  // edge timing monitor; instance i has DIV = i + 2
  always @(dc or rst_n) begin
    int now;
    now = int'($time);
    for (int i = 0; i < 4; i++) begin
      if (dc[i] !== dc_prev[i]) begin
        chg[i]++;
        if (rst_n === 1'b1) begin
          if (dc[i] === 1'b1) begin
            if (board !== ((i % 2 == 0) ? 1'b1 : 1'b0)) nalign[i]++;
            if (first_r[i] == 0) first_r[i] = now;
            else begin
              per_l[i] = now - last_r[i];
              nper[i]++;
              if (per_l[i] != (i + 2) * 20) nbad[i]++;
            end
            last_r[i] = now;
          end else begin
            if (board !== 1'b1) nalign[i]++;
            if (first_r[i] != 0) begin
              hi_l[i] = now - last_r[i];
              if (hi_l[i] != (i + 2) * 10) nbad[i]++;
            end
          end
        end
      end
      if (rst_n !== 1'b1) begin
        first_r[i] = 0;
        last_r[i] = 0;
        per_l[i] = 0;
        hi_l[i] = 0;
        nper[i] = 0;
        nbad[i] = 0;
        nalign[i] = 0;
      end
    end
    dc_prev = dc;
  end
  function automatic logic pos_at(input int div, input int pp);
    return pp >= 3 && ((pp - 3) % div) < (div + 1) / 2;
  endfunction
  function automatic logic model(input int div, input int pp, input logic at_pos);
    if (div % 2 == 0) return pos_at(div, pp);
    return at_pos ? (pos_at(div, pp) && pos_at(div, pp - 1)) : pos_at(div, pp);
  endfunction
  task automatic chk(input string nm, input int div, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s div=%0d got=%0d expected=%0d", nm, div, got, exp);
    end
  endtask
  task automatic half();
    logic [3:0] e, got;
    @(board);
    if (rst_n !== 1'b1) p = 0;
    else if (board) p++;
    for (int i = 0; i < 4; i++) e[i] = model(i + 2, p, board);
    sbq.push_back(e);
    #1;
    got = sbq.pop_front();
    tests++;
    if (dc !== got) begin
      fails++;
      $display("FAIL sb t=%0t dotclock=%b expected=%b", $time, dc, got);
    end
    tests++;
    for (int i = 0; i < 4; i++)
      if (chg[i] - snap[i] > 1) begin
        fails++;
        $display("FAIL glitch t=%0t div=%0d changes=%0d expected<=1", $time, i + 2, chg[i] - snap[i]);
        break;
      end
    for (int i = 0; i < 4; i++) snap[i] = chg[i];
  endtask
  task automatic check_table();
    for (int r = 0; r < 4; r++) begin
      int i;
      i = tbl[r].div - 2;
      chk("first_rise", tbl[r].div, first_r[i] - rel, tbl[r].first);
      chk("period", tbl[r].div, per_l[i], tbl[r].per);
      chk("high", tbl[r].div, hi_l[i], tbl[r].hi);
      chk("bad_periods", tbl[r].div, nbad[i], 0);
      chk("edge_align", tbl[r].div, nalign[i], 0);
      chk("periods_ge_100", tbl[r].div, int'(nper[i] >= 100), 1);
    end
  endtask
  initial begin
    int k;
    tbl[0] = '{2, 49, 40, 20};
    tbl[1] = '{3, 59, 60, 30};
    tbl[2] = '{4, 49, 80, 40};
    tbl[3] = '{5, 59, 100, 50};
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) snap[i] = chg[i];
    for (int n = 0; n < 10; n++) half();
    chk("reset_state", 0, int'(dc), 0);
    rst_n = 1'b1;
    rel = int'($time);
    for (int n = 0; n < 1300; n++) half();
    check_table();
    k = 0;
    do begin
      half();
      k++;
    end while (!(board === 1'b1 && dc[0] === 1'b1) && k < 40);
    chk("mid_wait_high", 2, int'(dc[0] === 1'b1), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_async", 0, int'(dc), 0);
    for (int n = 0; n < 7; n++) half();
    chk("release_phase", 0, int'(board), 0);
    rst_n = 1'b1;
    rel = int'($time);
    for (int n = 0; n < 1300; n++) half();
    check_table();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
